// File: rtl/pll_reconfig_pkg.sv
// Shared constants, state encoding and helpers for the PLL reconfiguration sequencer.
package pll_reconfig_pkg;

  localparam int unsigned ADDR_W  = 6;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned CNT_W   = 18;
  localparam int unsigned MFRAC_W = 32;
  localparam int unsigned BW_W    = 4;
  localparam int unsigned CP_W    = 3;
  localparam int unsigned CSEL_W  = 5;
  localparam int unsigned IDX_W   = 5;

  localparam logic [ADDR_W-1:0] ADDR_MODE  = 6'h00;
  localparam logic [ADDR_W-1:0] ADDR_START = 6'h02;
  localparam logic [ADDR_W-1:0] ADDR_N     = 6'h03;
  localparam logic [ADDR_W-1:0] ADDR_M     = 6'h04;
  localparam logic [ADDR_W-1:0] ADDR_C     = 6'h05;
  localparam logic [ADDR_W-1:0] ADDR_MFRAC = 6'h07;
  localparam logic [ADDR_W-1:0] ADDR_BW    = 6'h08;
  localparam logic [ADDR_W-1:0] ADDR_CP    = 6'h09;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_GAP,
    ST_LOCK,
    ST_DONE
  } state_t;

  // C-counter register word: counter select in [22:18], counter setting in [17:0].
  function automatic logic [DATA_W-1:0] pack_c_sel(input logic [CSEL_W-1:0] k,
                                                    input logic [CNT_W-1:0]  c);
    return {9'b0, k, c};
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop single-bit synchronizer with asynchronous active-low reset.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // Shift the asynchronous input through two flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_reconfig_seq.sv
// Avalon-MM master that writes one full PLL setting to the reconfiguration core,
// starts reconfiguration and waits for a stable lock or a timeout.
module pll_reconfig_seq
  import pll_reconfig_pkg::*;
#(
  parameter int unsigned NUM_C        = 2,
  parameter logic [21:0] LOCK_TIMEOUT = 22'd2_500_000,
  parameter logic [7:0]  LOCK_STABLE  = 8'd16
) (
  input  logic                     mgmt_clk,
  input  logic                     mgmt_reset_n,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [CNT_W-1:0]         cmd_n,
  input  logic [CNT_W-1:0]         cmd_m,
  input  logic [MFRAC_W-1:0]       cmd_mfrac,
  input  logic [NUM_C*CNT_W-1:0]   cmd_c,
  input  logic [BW_W-1:0]          cmd_bw,
  input  logic [CP_W-1:0]          cmd_cp,
  output logic [ADDR_W-1:0]        mgmt_address,
  output logic                     mgmt_write,
  output logic [DATA_W-1:0]        mgmt_writedata,
  output logic                     mgmt_read,
  input  logic                     mgmt_waitrequest,
  input  logic                     pll_locked,
  output logic                     busy,
  output logic                     done,
  output logic                     err
);

  localparam logic [IDX_W-1:0] IX_MODE  = IDX_W'(0);
  localparam logic [IDX_W-1:0] IX_N     = IDX_W'(1);
  localparam logic [IDX_W-1:0] IX_M     = IDX_W'(2);
  localparam logic [IDX_W-1:0] IX_MFRAC = IDX_W'(3);
  localparam int unsigned      IX_C0    = 4;
  localparam logic [IDX_W-1:0] IX_BW    = IDX_W'(IX_C0 + NUM_C);
  localparam logic [IDX_W-1:0] IX_CP    = IDX_W'(IX_C0 + NUM_C + 1);
  localparam logic [IDX_W-1:0] IX_START = IDX_W'(IX_C0 + NUM_C + 2);

  state_t                   state_q, state_d;
  logic                     ready_q;
  logic [IDX_W-1:0]         idx_q;
  logic [CNT_W-1:0]         n_q, m_q;
  logic [MFRAC_W-1:0]       mfrac_q;
  logic [NUM_C*CNT_W-1:0]   c_q;
  logic [BW_W-1:0]          bw_q;
  logic [CP_W-1:0]          cp_q;
  logic [21:0]              tmo_q;
  logic [7:0]               stable_q;
  logic                     err_q;
  logic                     locked_s;

  logic                     accept;
  logic                     wr_done;
  logic                     lock_ok;
  logic                     tmo_hit;
  logic [ADDR_W-1:0]        entry_addr;
  logic [DATA_W-1:0]        entry_data;
  logic [DATA_W-1:0]        c_word;
  logic                     c_hit;

  sync_2ff u_lock_sync (
    .clk   (mgmt_clk),
    .rst_n (mgmt_reset_n),
    .d     (pll_locked),
    .q     (locked_s)
  );

  assign accept    = cmd_valid && ready_q && (state_q == ST_IDLE);
  assign wr_done   = (state_q == ST_WRITE) && !mgmt_waitrequest;
  assign lock_ok   = locked_s && (({1'b0, stable_q} + 9'd1) >= {1'b0, LOCK_STABLE});
  assign tmo_hit   = ({1'b0, tmo_q} + 23'd1) >= {1'b0, LOCK_TIMEOUT};
  assign cmd_ready = ready_q;
  assign mgmt_read = 1'b0;
  assign err       = err_q;

  // Look up the register address and data for the current write index.
  always_comb begin
    c_word = '0;
    c_hit  = 1'b0;
    for (int unsigned i = 0; i < NUM_C; i++) begin
      if (idx_q == IDX_W'(IX_C0 + i)) begin
        c_word = pack_c_sel(CSEL_W'(i), c_q[i*CNT_W +: CNT_W]);
        c_hit  = 1'b1;
      end
    end
    entry_addr = ADDR_START;
    entry_data = '0;
    if (idx_q == IX_MODE) begin
      entry_addr = ADDR_MODE;
    end else if (idx_q == IX_N) begin
      entry_addr = ADDR_N;
      entry_data = {14'b0, n_q};
    end else if (idx_q == IX_M) begin
      entry_addr = ADDR_M;
      entry_data = {14'b0, m_q};
    end else if (idx_q == IX_MFRAC) begin
      entry_addr = ADDR_MFRAC;
      entry_data = mfrac_q;
    end else if (c_hit) begin
      entry_addr = ADDR_C;
      entry_data = c_word;
    end else if (idx_q == IX_BW) begin
      entry_addr = ADDR_BW;
      entry_data = {28'b0, bw_q};
    end else if (idx_q == IX_CP) begin
      entry_addr = ADDR_CP;
      entry_data = {29'b0, cp_q};
    end
  end

  // Next-state logic and bus/status outputs.
  always_comb begin
    state_d        = state_q;
    mgmt_write     = 1'b0;
    mgmt_address   = '0;
    mgmt_writedata = '0;
    busy           = 1'b0;
    done           = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) state_d = ST_WRITE;
      end
      ST_WRITE: begin
        mgmt_write     = 1'b1;
        mgmt_address   = entry_addr;
        mgmt_writedata = entry_data;
        busy           = 1'b1;
        if (!mgmt_waitrequest) state_d = (idx_q == IX_START) ? ST_LOCK : ST_GAP;
      end
      ST_GAP: begin
        busy    = 1'b1;
        state_d = ST_WRITE;
      end
      ST_LOCK: begin
        busy = 1'b1;
        if (lock_ok || tmo_hit) state_d = ST_DONE;
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register; ready is registered so it reads 0 while in reset.
  always_ff @(posedge mgmt_clk or negedge mgmt_reset_n) begin
    if (!mgmt_reset_n) begin
      state_q <= ST_IDLE;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d == ST_IDLE);
    end
  end

  // Command capture, write index, lock/timeout counters and error flag.
  always_ff @(posedge mgmt_clk or negedge mgmt_reset_n) begin
    if (!mgmt_reset_n) begin
      idx_q    <= '0;
      n_q      <= '0;
      m_q      <= '0;
      mfrac_q  <= '0;
      c_q      <= '0;
      bw_q     <= '0;
      cp_q     <= '0;
      tmo_q    <= '0;
      stable_q <= '0;
      err_q    <= 1'b0;
    end else begin
      if (accept) begin
        idx_q   <= '0;
        n_q     <= cmd_n;
        m_q     <= cmd_m;
        mfrac_q <= cmd_mfrac;
        c_q     <= cmd_c;
        bw_q    <= cmd_bw;
        cp_q    <= cmd_cp;
        err_q   <= 1'b0;
      end
      if (state_q == ST_GAP) idx_q <= idx_q + IDX_W'(1);
      // tmo_q counts elapsed cycles including the START completion edge.
      if (wr_done && (idx_q == IX_START)) begin
        tmo_q    <= 22'd1;
        stable_q <= '0;
      end else if (state_q == ST_LOCK) begin
        tmo_q <= (tmo_q == '1) ? tmo_q : tmo_q + 22'd1;
        if (locked_s) stable_q <= (stable_q == '1) ? stable_q : stable_q + 8'd1;
        else          stable_q <= '0;
        if (state_d == ST_DONE) err_q <= !lock_ok;
      end
    end
  end

endmodule

// File: tb/tb_pll_reconfig_seq.sv
// Self-checking bench: scoreboard of expected register writes plus lock/timeout timing checks.
module tb_pll_reconfig_seq;

  logic        clk = 1'b0;
  logic        mgmt_reset_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [17:0] cmd_n, cmd_m;
  logic [31:0] cmd_mfrac;
  logic [35:0] cmd_c;
  logic [3:0]  cmd_bw;
  logic [2:0]  cmd_cp;
  logic [5:0]  mgmt_address;
  logic        mgmt_write;
  logic [31:0] mgmt_writedata;
  logic        mgmt_read;
  logic        waitreq;
  logic        pll_locked;
  logic        busy, done, err;

  pll_reconfig_seq #(
    .NUM_C        (2),
    .LOCK_TIMEOUT (22'd1000),
    .LOCK_STABLE  (8'd16)
  ) dut (
    .mgmt_clk         (clk),
    .mgmt_reset_n     (mgmt_reset_n),
    .cmd_valid        (cmd_valid),
    .cmd_ready        (cmd_ready),
    .cmd_n            (cmd_n),
    .cmd_m            (cmd_m),
    .cmd_mfrac        (cmd_mfrac),
    .cmd_c            (cmd_c),
    .cmd_bw           (cmd_bw),
    .cmd_cp           (cmd_cp),
    .mgmt_address     (mgmt_address),
    .mgmt_write       (mgmt_write),
    .mgmt_writedata   (mgmt_writedata),
    .mgmt_read        (mgmt_read),
    .mgmt_waitrequest (waitreq),
    .pll_locked       (pll_locked),
    .busy             (busy),
    .done             (done),
    .err              (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Scoreboard of {address, data} in the order the sequencer must write them.
  logic [37:0] exp_q[$];

  task automatic push_cmd(input logic [17:0] n, input logic [17:0] m, input logic [31:0] mf,
                          input logic [17:0] c0, input logic [17:0] c1,
                          input logic [3:0] bw, input logic [2:0] cp);
    exp_q.push_back({6'h00, 32'h0});
    exp_q.push_back({6'h03, 14'h0, n});
    exp_q.push_back({6'h04, 14'h0, m});
    exp_q.push_back({6'h07, mf});
    exp_q.push_back({6'h05, 9'h0, 5'd0, c0});
    exp_q.push_back({6'h05, 9'h0, 5'd1, c1});
    exp_q.push_back({6'h08, 28'h0, bw});
    exp_q.push_back({6'h09, 29'h0, cp});
    exp_q.push_back({6'h02, 32'h0});
  endtask

  int          writes_cnt = 0, start_count = 0, done_count = 0, acc_count = 0;
  int          start_cyc = 0, done_cyc = 0, acc_cyc = 0;
  logic        done_err = 1'b0;
  logic        prev_wr = 1'b0, prev_wait = 1'b0, prev_done = 1'b0, prev_cmpl = 1'b0;
  logic [5:0]  prev_addr = '0;
  logic [31:0] prev_data = '0;

  // Bus monitor: pops the scoreboard on each completed write and checks bus rules.
  always @(negedge clk) begin
    logic [37:0] e;
    if (prev_wr && prev_wait && mgmt_reset_n) begin
      check_eq("hold_write", mgmt_write, 1);
      check_eq("hold_addr", mgmt_address, prev_addr);
      check_eq("hold_data", mgmt_writedata, prev_data);
    end
    if (prev_cmpl) check_eq("gap_cycle", mgmt_write, 0);
    if (prev_done) check_eq("done_one_cycle", done, 0);
    if (busy) check_eq("ready_while_busy", cmd_ready, 0);
    if (mgmt_write && !waitreq) begin
      writes_cnt++;
      check_eq("write_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check_eq("write_addr", mgmt_address, e[37:32]);
        check_eq("write_data", mgmt_writedata, e[31:0]);
      end
      if (mgmt_address == 6'h02) begin
        start_count++;
        start_cyc = cyc;
      end
    end
    if (done) begin
      done_count++;
      done_cyc = cyc;
      done_err = err;
    end
    if (cmd_valid && cmd_ready) begin
      acc_count++;
      acc_cyc = cyc;
    end
    prev_wr   = mgmt_write;
    prev_wait = waitreq;
    prev_addr = mgmt_address;
    prev_data = mgmt_writedata;
    prev_done = done;
    prev_cmpl = mgmt_write && !waitreq;
  end

  // Slave model: optional one-shot stalls on the M write and on the START write.
  bit arm_m = 0, arm_s = 0;
  int stall_cnt = 0;
  initial begin
    waitreq = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (stall_cnt > 0) begin
        stall_cnt--;
        waitreq = 1'b1;
      end else if (arm_m && mgmt_write && mgmt_address == 6'h04) begin
        arm_m = 0; stall_cnt = 4; waitreq = 1'b1;
      end else if (arm_s && mgmt_write && mgmt_address == 6'h02) begin
        arm_s = 0; stall_cnt = 999; waitreq = 1'b1;
      end else begin
        waitreq = 1'b0;
      end
    end
  end

  task automatic drive_fields(input logic [17:0] n, input logic [17:0] m, input logic [31:0] mf,
                              input logic [17:0] c0, input logic [17:0] c1,
                              input logic [3:0] bw, input logic [2:0] cp);
    cmd_n = n; cmd_m = m; cmd_mfrac = mf; cmd_c = {c1, c0}; cmd_bw = bw; cmd_cp = cp;
    push_cmd(n, m, mf, c0, c1, bw, cp);
  endtask

  task automatic send_cmd(input logic [17:0] n, input logic [17:0] m, input logic [31:0] mf,
                          input logic [17:0] c0, input logic [17:0] c1,
                          input logic [3:0] bw, input logic [2:0] cp, input bit keep);
    int a0;
    bit hit;
    @(posedge clk); #1;
    drive_fields(n, m, mf, c0, c1, bw, cp);
    cmd_valid = 1'b1;
    a0 = acc_count;
    hit = 0;
    for (int i = 0; i < 200 && !hit; i++) begin
      @(posedge clk); #1;
      if (acc_count != a0) hit = 1;
    end
    check_eq("cmd_accepted", hit, 1);
    if (!keep) cmd_valid = 1'b0;
  endtask

  task automatic wait_start(input int max_cyc);
    int s0;
    bit hit;
    s0 = start_count;
    hit = 0;
    for (int i = 0; i < max_cyc && !hit; i++) begin
      @(negedge clk); #1;
      if (start_count != s0) hit = 1;
    end
    check_eq("start_within_budget", hit, 1);
  endtask

  task automatic wait_done(input int max_cyc);
    int d0;
    bit hit;
    d0 = done_count;
    hit = 0;
    for (int i = 0; i < max_cyc && !hit; i++) begin
      @(negedge clk); #1;
      if (done_count != d0) hit = 1;
    end
    check_eq("done_within_budget", hit, 1);
  endtask

  int lock_cyc, d_a, d0;
  bit found;

  initial begin
    mgmt_reset_n = 1'b0;
    cmd_valid = 1'b0;
    cmd_n = '0; cmd_m = '0; cmd_mfrac = '0; cmd_c = '0; cmd_bw = '0; cmd_cp = '0;
    pll_locked = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check_eq("rst_cmd_ready", cmd_ready, 0);
    check_eq("rst_write", mgmt_write, 0);
    check_eq("rst_addr", mgmt_address, 0);
    check_eq("rst_data", mgmt_writedata, 0);
    check_eq("rst_read", mgmt_read, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_err", err, 0);
    @(posedge clk); #1 mgmt_reset_n = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("idle_ready", cmd_ready, 1);

    // Basic sequence, lock 100 cycles after START
    writes_cnt = 0;
    send_cmd(18'h10101, 18'h00404, 32'h0, 18'h00404, 18'h00404, 4'd6, 3'd1, 0);
    check_eq("busy_after_accept", busy, 1);
    wait_start(100);
    repeat (100) @(posedge clk);
    #1 pll_locked = 1'b1; lock_cyc = cyc;
    wait_done(200);
    check_eq("basic_lock_latency", done_cyc - lock_cyc, 18);
    check_eq("basic_err", done_err, 0);
    check_eq("basic_writes", writes_cnt, 9);
    check_eq("basic_queue_empty", exp_q.size(), 0);
    @(negedge clk);
    check_eq("basic_busy_after_done", busy, 0);
    check_eq("basic_err_held", err, 0);
    @(posedge clk); #1 pll_locked = 1'b0;

    // Waitrequest stalls on M (5 cycles) and START (1000 cycles)
    arm_m = 1; arm_s = 1;
    writes_cnt = 0;
    send_cmd(18'h20302, 18'h0A0B1, 32'h8000_0001, 18'h10202, 18'h3FFFF, 4'hA, 3'd5, 0);
    wait_start(1200);
    repeat (40) @(posedge clk);
    #1 pll_locked = 1'b1; lock_cyc = cyc;
    wait_done(100);
    check_eq("stall_lock_latency", done_cyc - lock_cyc, 18);
    check_eq("stall_err", done_err, 0);
    check_eq("stall_writes", writes_cnt, 9);
    check_eq("stall_queue_empty", exp_q.size(), 0);
    @(posedge clk); #1 pll_locked = 1'b0;

    // Lock timeout
    writes_cnt = 0;
    send_cmd(18'h00505, 18'h00707, 32'h1234_5678, 18'h00101, 18'h20303, 4'd3, 3'd2, 0);
    wait_start(100);
    wait_done(1100);
    check_eq("timeout_latency", done_cyc - start_cyc, 1000);
    check_eq("timeout_err", done_err, 1);
    @(negedge clk);
    check_eq("timeout_busy_after", busy, 0);
    repeat (3) @(negedge clk);
    check_eq("timeout_err_held", err, 1);

    // Glitchy lock: 10 high, 1 low, then high
    writes_cnt = 0;
    send_cmd(18'h00808, 18'h10909, 32'hDEAD_BEEF, 18'h00202, 18'h00303, 4'd7, 3'd3, 0);
    check_eq("err_cleared_on_accept", err, 0);
    wait_start(100);
    repeat (20) @(posedge clk);
    #1 pll_locked = 1'b1;
    repeat (10) @(posedge clk);
    #1 pll_locked = 1'b0;
    @(posedge clk);
    #1 pll_locked = 1'b1; lock_cyc = cyc;
    wait_done(100);
    check_eq("glitch_lock_latency", done_cyc - lock_cyc, 18);
    check_eq("glitch_err", done_err, 0);
    check_eq("glitch_writes", writes_cnt, 9);
    @(posedge clk); #1 pll_locked = 1'b0;

    // Backpressure: second command held valid during busy; stale lock on the second
    writes_cnt = 0;
    send_cmd(18'h01111, 18'h02222, 32'h0000_00AA, 18'h03333, 18'h04444, 4'd1, 3'd4, 1);
    drive_fields(18'h35555, 18'h06666, 32'h0BAD_F00D, 18'h07777, 18'h18888, 4'd9, 3'd6);
    wait_start(100);
    repeat (30) @(posedge clk);
    #1 pll_locked = 1'b1;
    wait_done(100);
    d_a = done_cyc;
    check_eq("bp_first_err", done_err, 0);
    found = 0;
    d0 = acc_count;
    for (int i = 0; i < 10 && !found; i++) begin
      @(posedge clk); #1;
      if (acc_count != d0) found = 1;
    end
    cmd_valid = 1'b0;
    check_eq("bp_second_accepted", found, 1);
    check_eq("bp_accept_cycle", acc_cyc - d_a, 1);
    wait_start(100);
    wait_done(100);
    check_eq("stale_lock_latency", done_cyc - start_cyc, 17);
    check_eq("bp_second_err", done_err, 0);
    check_eq("bp_writes", writes_cnt, 18);
    check_eq("bp_queue_empty", exp_q.size(), 0);
    @(posedge clk); #1 pll_locked = 1'b0;

    // Reset during the C0 write
    send_cmd(18'h0ABCD, 18'h01234, 32'h5555_AAAA, 18'h00F0F, 18'h00E0E, 4'd2, 3'd7, 0);
    found = 0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(posedge clk); #1;
      if (mgmt_write && mgmt_address == 6'h05) found = 1;
    end
    check_eq("reached_c0_write", found, 1);
    d0 = done_count;
    #2 mgmt_reset_n = 1'b0;
    #1;
    check_eq("reset_write_drop", mgmt_write, 0);
    check_eq("reset_busy_drop", busy, 0);
    check_eq("reset_addr_clear", mgmt_address, 0);
    repeat (3) @(posedge clk);
    #1 mgmt_reset_n = 1'b1;
    exp_q.delete();
    repeat (20) @(negedge clk);
    check_eq("no_done_on_reset", done_count, d0);
    check_eq("ready_after_reset", cmd_ready, 1);
    writes_cnt = 0;
    send_cmd(18'h00606, 18'h00C0C, 32'h0000_0001, 18'h00404, 18'h00808, 4'd5, 3'd0, 0);
    wait_start(100);
    repeat (10) @(posedge clk);
    #1 pll_locked = 1'b1; lock_cyc = cyc;
    wait_done(100);
    check_eq("post_reset_lock_latency", done_cyc - lock_cyc, 18);
    check_eq("post_reset_err", done_err, 0);
    check_eq("post_reset_writes", writes_cnt, 9);
    check_eq("post_reset_queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pll_reconfig_seq.md
Name: pll_reconfig_seq

Overview:
- Avalon-MM master that drives the management port of the Cyclone V PLL reconfiguration core.
- That core sits on the 64-bit reconfig_to_pll / reconfig_from_pll buses of the system PLL wrapper.
- Accepts one complete PLL setting per command (N, M, fractional M, C0..C(NUM_C-1), bandwidth, charge pump), writes it register by register, starts reconfiguration, then waits for lock or timeout.
- Used by the memory-test frequency stepper to retune SDRAM clock frequency and phase at run time.

Parameters:
- NUM_C, 2, number of C output counters written per command (1..18).
- LOCK_TIMEOUT, 22'd2_500_000, clk cycles from the start write until lock is declared failed (50 ms at 50 MHz).
- LOCK_STABLE, 8'd16, consecutive synchronized locked=1 cycles required before lock is accepted.

Ports:
- mgmt_clk, in, 1, single clock for all logic.
- mgmt_reset_n, in, 1, asynchronous active-low reset.
- cmd_valid, in, 1, command present.
- cmd_ready, out, 1, command accepted when cmd_valid && cmd_ready.
- cmd_n, in, 18, N counter word: [7:0] lo, [15:8] hi, [16] bypass, [17] odd.
- cmd_m, in, 18, M counter word, same format as cmd_n.
- cmd_mfrac, in, 32, fractional M value.
- cmd_c, in, NUM_C*18, C counter words; C index k occupies [18k+17:18k].
- cmd_bw, in, 4, bandwidth setting.
- cmd_cp, in, 3, charge-pump setting.
- mgmt_address, out, 6, register address.
- mgmt_write, out, 1, write strobe.
- mgmt_writedata, out, 32, write data.
- mgmt_read, out, 1, tied 0.
- mgmt_waitrequest, in, 1, slave stall.
- pll_locked, in, 1, PLL locked; asynchronous to mgmt_clk.
- busy, out, 1, sequence in progress.
- done, out, 1, one-cycle completion pulse.
- err, out, 1, valid with done: 1 = lock timeout.

Behaviour:
- Reset values: cmd_ready=0, mgmt_write=0, mgmt_address=0, mgmt_writedata=0, busy=0, done=0, err=0. The lock synchronizer and all counters clear.
- Reset asserted mid-sequence aborts immediately. mgmt_write drops asynchronously. No done pulse is issued.
- States:
  - IDLE: cmd_ready=1. On handshake, latch all cmd_* fields, clear write index, go to WRITE. busy goes 1 the next cycle.
  - WRITE: drive the table entry at the current index. Hold mgmt_write, address and data stable while mgmt_waitrequest=1. On mgmt_waitrequest=0 the transfer completes; go to GAP. If the completed entry was START, go to LOCK instead.
  - GAP: mgmt_write=0 for exactly one cycle. Increment index, go to WRITE.
  - LOCK: timeout counter runs from the START completion. Stable counter increments while synced locked=1 and resets to 0 when it is 0. When stable reaches LOCK_STABLE, go to DONE with err=0. When timeout reaches LOCK_TIMEOUT first, go to DONE with err=1. If both happen in the same cycle, lock wins (err=0).
  - DONE: done=1 for one cycle, err held until the next accepted command, busy=0. Return to IDLE.
- Write table, in order (address, data):
  - 0x00, 0 (waitrequest mode).
  - 0x03, {14'b0, n}.
  - 0x04, {14'b0, m}.
  - 0x07, mfrac.
  - 0x05, {9'b0, k[4:0], c_k} for k=0..NUM_C-1.
  - 0x08, {28'b0, bw}.
  - 0x09, {29'b0, cp}.
  - 0x02, 0 (START).
  - Total writes = 7 + NUM_C.
- Commands are never accepted while busy. cmd_valid during busy is ignored and is not queued.
- pll_locked goes through a 2-FF synchronizer, giving 2-cycle latency.
- A lock already high before START (stale) is tolerated: stable counting begins only after the START write completes.
- Counters saturate. No wrap-around.

Decomposition:
- pll_reconfig_pkg holds:
  - register address constants (MODE, START, N, M, C, MFRAC, BW, CP);
  - field width constants;
  - state enum;
  - pack function for the C-select word.
- One sub-module: sync_2ff (generic 2-flop bit synchronizer, async active-low reset) for pll_locked.

Test Plan:
- Basic sequence, NUM_C=2, waitrequest always 0, pll_locked rises 100 cycles after START:
  - stimulus: n=0x10101, m=0x00404, c0=0x00404, c1=0x00404, mfrac=0, bw=6, cp=1;
  - response: 9 writes in table order, C words 0x00404 then 0x40404, one-cycle gaps, done=1 err=0 exactly 2+16 cycles after the first stable lock cycle.
- Waitrequest stall: slave holds waitrequest for 5 cycles on the M write and 1000 cycles on START → address and data stable throughout, no duplicate writes, write count still 9.
- Timeout: LOCK_TIMEOUT=1000 and pll_locked stuck 0 → done=1 err=1 exactly 1000 cycles after START completion, busy=0 next cycle.
- Glitchy lock: locked toggles 1 for 10 cycles, 0 for 1 cycle, then stays 1 → stable counter restarts; done only after 16 continuous high cycles.
- Backpressure: second cmd_valid held high during busy → cmd_ready=0 until after done; second command accepted the cycle after return to IDLE, with its own data.
- Reset mid-sequence: assert mgmt_reset_n=0 during the C0 write → mgmt_write=0 immediately, no done pulse; after release, cmd_ready=1 and a new command runs cleanly from the MODE write.
